regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 6 +
 rtl/rr_arb2.sv | 18 +
 rtl/regfile_wb_arbiter.sv | 64 ++++++
 tb/tb_regfile_wb_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and requester ids for the writeback arbiter
package regfile_pkg;
  localparam int DEF_RWIDTH = 6;
  localparam int DEF_DWIDTH = 32;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, bit 0 = ALU, bit 1 = MEM
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  req_id_e last;
  always_comb begin
    gnt = !rst_n ? 2'b00 : &req ? ((last == REQ_MEM) ? 2'b01 : 2'b10) : req;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) last <= REQ_MEM;
    else if (&req) last <= gnt[1] ? REQ_MEM : REQ_ALU;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU/load writeback arbiter with registered write port; WB_BYPASS_EN adds read bypass
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int RWIDTH = DEF_RWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [RWIDTH-1:0] alu_wa,
  input  logic [DWIDTH-1:0] alu_wd,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [RWIDTH-1:0] mem_wa,
  input  logic [DWIDTH-1:0] mem_wd,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [RWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  input  logic [RWIDTH-1:0] pipe_ra1,
  input  logic [RWIDTH-1:0] pipe_ra2,
  output logic [RWIDTH-1:0] rf_ra1,
  output logic [RWIDTH-1:0] rf_ra2,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2,
  output logic [DWIDTH-1:0] pipe_rd1,
  output logic [DWIDTH-1:0] pipe_rd2,
  output logic [15:0]       conflict_cnt
);
  logic [1:0] gnt;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({mem_valid, alu_valid}),
    .gnt  (gnt)
  );
  assign alu_ready = gnt[0];
  assign mem_ready = gnt[1];
  assign rf_ra1 = pipe_ra1;
  assign rf_ra2 = pipe_ra2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we        <= 1'b0;
      rf_wa        <= '0;
      rf_wd        <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_we <= |gnt;
      if (|gnt) begin
        rf_wa <= gnt[1] ? mem_wa : alu_wa;
        rf_wd <= gnt[1] ? mem_wd : alu_wd;
      end
      if (alu_valid && mem_valid && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`ifdef WB_BYPASS_EN
  assign pipe_rd1 = (rf_we && rf_wa == pipe_ra1) ? rf_wd : rf_rd1;
  assign pipe_rd2 = (rf_we && rf_wa == pipe_ra2) ? rf_wd : rf_rd2;
`else
  assign pipe_rd1 = rf_rd1;
  assign pipe_rd2 = rf_rd2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table vectors plus reset and saturation sequences against a scoreboard model
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, alu_ready, mem_ready, rf_we;
  logic [5:0]  alu_wa, mem_wa, rf_wa, pipe_ra1, pipe_ra2, rf_ra1, rf_ra2;
  logic [31:0] alu_wd, mem_wd, rf_wd, rf_rd1, rf_rd2, pipe_rd1, pipe_rd2;
  logic [15:0] conflict_cnt;

  regfile_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pipe_ra1(pipe_ra1), .pipe_ra2(pipe_ra2), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .pipe_rd1(pipe_rd1), .pipe_rd2(pipe_rd2),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [5:0] aw; logic [31:0] ad;
    logic mv; logic [5:0] mw; logic [31:0] md;
    logic ea; logic em;
  } vec_t;

  vec_t        tab[12];
  logic [37:0] q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        m_last;
  logic [15:0] m_cnt;
  logic [5:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_gnt(input logic av, input logic mv);
    return (av && mv) ? (m_last ? 2'b01 : 2'b10) : {mv, av};
  endfunction

  task automatic step(input logic av, input logic [5:0] aw, input logic [31:0] ad,
                      input logic mv, input logic [5:0] mw, input logic [31:0] md,
                      input logic ea, input logic em);
    logic [37:0] e;
    logic        exp_we;
    logic [31:0] exp1, exp2;
    alu_valid = av; alu_wa = aw; alu_wd = ad;
    mem_valid = mv; mem_wa = mw; mem_wd = md;
    #4;
    chk("alu_ready", alu_ready, ea);
    chk("mem_ready", mem_ready, em);
    if (ea) q.push_back({aw, ad});
    else if (em) q.push_back({mw, md});
    if (av && mv) begin
      if (m_cnt != 16'hFFFF) m_cnt++;
      m_last = em;
    end
    @(posedge clk);
    #1;
    exp_we = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = 1'b1;
      m_wa = e[37:32];
      m_wd = e[31:0];
    end
    chk("rf_we", rf_we, exp_we);
    chk("rf_wa", rf_wa, m_wa);
    chk("rf_wd", rf_wd, m_wd);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("rf_ra1", rf_ra1, pipe_ra1);
    chk("rf_ra2", rf_ra2, pipe_ra2);
`ifdef WB_BYPASS_EN
    exp1 = (exp_we && m_wa == pipe_ra1) ? m_wd : rf_rd1;
    exp2 = (exp_we && m_wa == pipe_ra2) ? m_wd : rf_rd2;
`else
    exp1 = rf_rd1;
    exp2 = rf_rd2;
`endif
    chk("pipe_rd1", pipe_rd1, exp1);
    chk("pipe_rd2", pipe_rd2, exp2);
  endtask

  initial begin
    logic [1:0] g;
    tab[0]  = '{1'b1, 6'h0C, 32'hAAAAAAAA, 1'b0, 6'h00, 32'h0,        1'b1, 1'b0};
    tab[1]  = '{1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 32'h0,        1'b0, 1'b0};
    tab[2]  = '{1'b1, 6'h01, 32'h11111111, 1'b1, 6'h02, 32'h22222222, 1'b1, 1'b0};
    tab[3]  = '{1'b0, 6'h00, 32'h0,        1'b1, 6'h02, 32'h22222222, 1'b0, 1'b1};
    tab[4]  = '{1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 32'h0,        1'b0, 1'b0};
    tab[5]  = '{1'b1, 6'h3F, 32'hFFAAFFAA, 1'b1, 6'h3F, 32'hBBBBBBBB, 1'b0, 1'b1};
    tab[6]  = '{1'b1, 6'h3F, 32'hFFAAFFAA, 1'b0, 6'h00, 32'h0,        1'b1, 1'b0};
    tab[7]  = '{1'b1, 6'h3F, 32'h12345678, 1'b0, 6'h00, 32'h0,        1'b1, 1'b0};
    tab[8]  = '{1'b0, 6'h00, 32'h0,        1'b1, 6'h00, 32'h00001234, 1'b0, 1'b1};
    tab[9]  = '{1'b1, 6'h07, 32'h70707070, 1'b1, 6'h08, 32'h80808080, 1'b1, 1'b0};
    tab[10] = '{1'b1, 6'h09, 32'h90909090, 1'b1, 6'h08, 32'h80808080, 1'b0, 1'b1};
    tab[11] = '{1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 32'h0,        1'b0, 1'b0};
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_wa = 6'h11; alu_wd = 32'h1;
    mem_valid = 1'b1; mem_wa = 6'h12; mem_wd = 32'h2;
    pipe_ra1 = 6'h3F; pipe_ra2 = 6'h00;
    rf_rd1 = 32'hC0DE0001; rf_rd2 = 32'hC0DE0002;
    m_last = 1'b1; m_cnt = '0; m_wa = '0; m_wd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst alu_ready", alu_ready, 1'b0);
    chk("rst mem_ready", mem_ready, 1'b0);
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst rf_wa", rf_wa, 6'h0);
    chk("rst rf_wd", rf_wd, 32'h0);
    chk("rst conflict_cnt", conflict_cnt, 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++)
      step(tab[i].av, tab[i].aw, tab[i].ad, tab[i].mv, tab[i].mw, tab[i].md, tab[i].ea, tab[i].em);
    // accepted load write is staged, then reset lands on the capturing edge
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_wa = 6'h05; mem_wd = 32'hDEADBEEF;
    #4;
    chk("drop mem_ready", mem_ready, 1'b1);
    rst_n = 1'b0;
    alu_valid = 1'b1;
    #1;
    chk("drop alu_ready in rst", alu_ready, 1'b0);
    chk("drop mem_ready in rst", mem_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("drop rf_we", rf_we, 1'b0);
    chk("drop rf_wa", rf_wa, 6'h0);
    chk("drop rf_wd", rf_wd, 32'h0);
    chk("drop conflict_cnt", conflict_cnt, 16'h0);
    rst_n = 1'b1;
    m_last = 1'b1; m_cnt = '0; m_wa = '0; m_wd = '0;
    q.delete();
    for (int i = 0; i < 70000; i++) begin
      g = model_gnt(1'b1, 1'b1);
      step(1'b1, 6'(i), 32'(i) ^ 32'hA5A50000, 1'b1, 6'(i + 1), 32'(i) ^ 32'h5A5A0000, g[0], g[1]);
    end
    chk("sat conflict_cnt", conflict_cnt, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
